// File: rtl/mem_stream_reader.sv
// Burst reader: streams burst_len words starting at base_addr from a fixed-latency
// synchronous memory into a ready/valid output through a credit-protected FIFO.
module mem_stream_reader #(
  parameter int unsigned DATAWIDTH_p  = 32,
  parameter int unsigned MEM_DEPTH_p  = 153600,
  parameter int unsigned RD_LATENCY_p = 1,
  parameter int unsigned FIFO_DEPTH_p = 4,
  localparam int unsigned ADDRWIDTH_c = $clog2(MEM_DEPTH_p)
) (
  input  logic                   clk_drv,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   start,
  input  logic [ADDRWIDTH_c-1:0] base_addr,
  input  logic [ADDRWIDTH_c:0]   burst_len,
  output logic                   busy,
  output logic                   done,
  output logic [ADDRWIDTH_c-1:0] sdpmem_rdaddr,
  input  logic [DATAWIDTH_p-1:0] sdpmem_rddata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATAWIDTH_p-1:0] out_data,
  output logic                   out_last
);

  localparam int unsigned FAW = $clog2(FIFO_DEPTH_p);
  localparam int unsigned CW  = $clog2(FIFO_DEPTH_p + RD_LATENCY_p + 1) + 1;

  localparam logic [ADDRWIDTH_c-1:0] ADDR_MAX = ADDRWIDTH_c'(MEM_DEPTH_p - 1);
  localparam logic [ADDRWIDTH_c-1:0] ADDR_ONE = ADDRWIDTH_c'(1);
  localparam logic [ADDRWIDTH_c:0]   LEN_ONE  = (ADDRWIDTH_c + 1)'(1);
  localparam logic [FAW-1:0]         PTR_ONE  = FAW'(1);
  localparam logic [FAW:0]           CNT_ONE  = (FAW + 1)'(1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                   state;
  logic [ADDRWIDTH_c-1:0]   rd_addr;
  logic [ADDRWIDTH_c-1:0]   addr_hold;
  logic [ADDRWIDTH_c-1:0]   next_addr;
  logic [ADDRWIDTH_c:0]     remaining;
  logic [RD_LATENCY_p-1:0]  pipe_v;
  logic [RD_LATENCY_p-1:0]  pipe_last;
  logic [DATAWIDTH_p-1:0]   fifo_data [FIFO_DEPTH_p];
  logic [FIFO_DEPTH_p-1:0]  fifo_last;
  logic [FAW-1:0]           wr_ptr;
  logic [FAW-1:0]           rd_ptr;
  logic [FAW:0]             fifo_count;
  logic [CW-1:0]            inflight;
  logic                     credit_ok;
  logic                     issue;
  logic                     push;
  logic                     pop;
  logic                     last_accept;
  logic                     zero_done;

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < RD_LATENCY_p; i++) begin
      inflight = inflight + CW'(pipe_v[i]);
    end
  end

  // Reserve a FIFO slot for every read still travelling through the memory pipe.
  assign credit_ok   = (CW'(fifo_count) + inflight + CW'(1)) <= CW'(FIFO_DEPTH_p);
  assign issue       = enable && (state == READ) && credit_ok;
  assign push        = enable && pipe_v[RD_LATENCY_p-1];
  assign out_valid   = (fifo_count != '0);
  assign pop         = enable && out_valid && out_ready;
  assign out_data    = out_valid ? fifo_data[rd_ptr] : '0;
  assign out_last    = out_valid && fifo_last[rd_ptr];
  assign last_accept = pop && out_last && (state == DRAIN);
  assign done        = zero_done || last_accept;
  assign next_addr   = (rd_addr == ADDR_MAX) ? '0 : rd_addr + ADDR_ONE;
  assign sdpmem_rdaddr = issue ? rd_addr : addr_hold;

  always_ff @(posedge clk_drv or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      zero_done <= 1'b0;
      rd_addr   <= '0;
      addr_hold <= '0;
      remaining <= '0;
      pipe_v    <= '0;
      pipe_last <= '0;
    end else if (enable) begin
      zero_done <= 1'b0;
      for (int unsigned i = RD_LATENCY_p - 1; i >= 1; i--) begin
        pipe_v[i]    <= pipe_v[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
      pipe_v[0]    <= issue;
      pipe_last[0] <= issue && (remaining == LEN_ONE);
      unique case (state)
        IDLE: begin
          if (start) begin
            if (burst_len != '0) begin
              rd_addr   <= base_addr;
              remaining <= burst_len;
              state     <= READ;
              busy      <= 1'b1;
            end else begin
              zero_done <= 1'b1;
            end
          end
        end
        READ: begin
          if (issue) begin
            addr_hold <= rd_addr;
            rd_addr   <= next_addr;
            remaining <= remaining - LEN_ONE;
            if (remaining == LEN_ONE) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_accept) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_drv or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (enable) begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_ONE;
        2'b01:   fifo_count <= fifo_count - CNT_ONE;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage needs no reset: the count gates every read of it.
  always_ff @(posedge clk_drv) begin
    if (push) begin
      fifo_data[wr_ptr] <= sdpmem_rddata;
      fifo_last[wr_ptr] <= pipe_last[RD_LATENCY_p-1];
    end
  end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Drives two readers (read latency 1 and 2) with identical stimulus and checks each
// delivered stream against the expected word sequence (base+i) mod depth.
module tb_mem_stream_reader;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 40;
  localparam int unsigned AW    = 6;
  localparam int unsigned FD    = 4;

  logic          clk_drv = 1'b0;
  logic          reset_n;
  logic          enable;
  logic          start;
  logic          out_ready;
  logic [AW-1:0] base_addr;
  logic [AW:0]   burst_len;

  logic          busy      [2];
  logic          done      [2];
  logic          out_valid [2];
  logic          out_last  [2];
  logic [AW-1:0] rdaddr    [2];
  logic [DW-1:0] rddata    [2];
  logic [DW-1:0] out_data  [2];

  int          checks   = 0;
  int          failures = 0;
  int unsigned exp_base = 0;
  int unsigned exp_len  = 0;
  int unsigned idx       [2];
  bit          active    [2];
  bit          zero_pend [2];
  logic [DW-1:0] last_word [2];

  always #5 clk_drv = ~clk_drv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    mem_stream_reader #(
      .DATAWIDTH_p (DW),
      .MEM_DEPTH_p (DEPTH),
      .RD_LATENCY_p(g + 1),
      .FIFO_DEPTH_p(FD)
    ) dut (
      .clk_drv      (clk_drv),
      .reset_n      (reset_n),
      .enable       (enable),
      .start        (start),
      .base_addr    (base_addr),
      .burst_len    (burst_len),
      .busy         (busy[g]),
      .done         (done[g]),
      .sdpmem_rdaddr(rdaddr[g]),
      .sdpmem_rddata(rddata[g]),
      .out_valid    (out_valid[g]),
      .out_ready    (out_ready),
      .out_data     (out_data[g]),
      .out_last     (out_last[g])
    );

    // Memory contents: word at address a holds a.
    if (g == 0) begin : gen_mem1
      logic [DW-1:0] m0;
      always @(posedge clk_drv) if (enable) m0 <= DW'(rdaddr[g]);
      assign rddata[g] = m0;
    end else begin : gen_mem2
      logic [DW-1:0] m0, m1;
      always @(posedge clk_drv) if (enable) begin
        m0 <= DW'(rdaddr[g]);
        m1 <= m0;
      end
      assign rddata[g] = m1;
    end

    bit            xfer, exp_last, frz_on;
    logic          frz_busy, frz_valid, frz_last;
    logic [DW-1:0] frz_data;

    always @(negedge clk_drv) begin
      if (reset_n) begin
        chk($sformatf("busy[L%0d]", g + 1), 32'(busy[g]), 32'(active[g]));
        if (frz_on) begin
          chk($sformatf("freeze_busy[L%0d]", g + 1), 32'(busy[g]), 32'(frz_busy));
          chk($sformatf("freeze_valid[L%0d]", g + 1), 32'(out_valid[g]), 32'(frz_valid));
          chk($sformatf("freeze_data[L%0d]", g + 1), out_data[g], frz_data);
          chk($sformatf("freeze_last[L%0d]", g + 1), 32'(out_last[g]), 32'(frz_last));
        end
        frz_on    = !enable;
        frz_busy  = busy[g];
        frz_valid = out_valid[g];
        frz_data  = out_data[g];
        frz_last  = out_last[g];
        if (!active[g]) chk($sformatf("idle_valid[L%0d]", g + 1), 32'(out_valid[g]), 32'd0);
        xfer     = enable && out_valid[g] && out_ready;
        exp_last = 1'b0;
        if (xfer && active[g]) begin
          chk($sformatf("data[L%0d] #%0d", g + 1, idx[g]), out_data[g], (exp_base + idx[g]) % DEPTH);
          exp_last = (idx[g] + 1 == exp_len);
          chk($sformatf("last[L%0d] #%0d", g + 1, idx[g]), 32'(out_last[g]), 32'(exp_last));
          last_word[g] = out_data[g];
          idx[g]++;
        end
        chk($sformatf("done[L%0d]", g + 1), 32'(done[g]), 32'(exp_last || zero_pend[g]));
        if (enable) zero_pend[g] = 1'b0;
        if (exp_last) active[g] = 1'b0;
      end else begin
        frz_on = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk_drv);
    #2;
  endtask

  task automatic launch(input int unsigned b, input int unsigned n);
    start     = 1'b1;
    base_addr = AW'(b);
    burst_len = (AW + 1)'(n);
    step();
    start    = 1'b0;
    exp_base = b;
    exp_len  = n;
    for (int g = 0; g < 2; g++) begin
      idx[g]       = 0;
      active[g]    = (n != 0);
      zero_pend[g] = (n == 0);
    end
  endtask

  task automatic wait_idle(input string name, input int unsigned budget);
    int unsigned c = 0;
    while ((active[0] || active[1]) && c < budget) begin
      step();
      c++;
    end
    chk({name, "_complete"}, 32'(active[0] || active[1]), 32'd0);
  endtask

  task automatic check_addrs(input string name, input int unsigned a0, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk_drv);
      for (int g = 0; g < 2; g++)
        chk($sformatf("%s[L%0d] #%0d", name, g + 1, i), 32'(rdaddr[g]), (a0 + i) % DEPTH);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] lfsr;
    int unsigned c;
    reset_n   = 1'b0;
    enable    = 1'b1;
    start     = 1'b0;
    out_ready = 1'b1;
    base_addr = '0;
    burst_len = '0;
    for (int g = 0; g < 2; g++) begin
      idx[g] = 0; active[g] = 1'b0; zero_pend[g] = 1'b0; last_word[g] = '0;
    end
    repeat (3) step();
    for (int g = 0; g < 2; g++) begin
      chk("rst_busy", 32'(busy[g]), 32'd0);
      chk("rst_done", 32'(done[g]), 32'd0);
      chk("rst_valid", 32'(out_valid[g]), 32'd0);
      chk("rst_last", 32'(out_last[g]), 32'd0);
      chk("rst_data", out_data[g], 32'd0);
      chk("rst_addr", 32'(rdaddr[g]), 32'd0);
    end
    reset_n = 1'b1;
    step();

    // Basic burst: addresses 10..14 on consecutive cycles.
    launch(10, 5);
    check_addrs("addr_basic", 10, 5);
    wait_idle("basic", 40);
    for (int g = 0; g < 2; g++) chk("basic_last_word", last_word[g], 32'd14);

    // Wrap at the end of memory.
    launch(DEPTH - 2, 4);
    check_addrs("addr_wrap", DEPTH - 2, 4);
    wait_idle("wrap", 40);
    for (int g = 0; g < 2; g++) chk("wrap_last_word", last_word[g], 32'd1);

    // Zero-length burst: done next cycle, no reads.
    launch(7, 0);
    repeat (3) step();
    for (int g = 0; g < 2; g++) chk("zero_addr_held", 32'(rdaddr[g]), 32'd1);

    // Backpressure: reads stop at the FIFO depth; a start while busy is ignored.
    out_ready = 1'b0;
    launch(5, 16);
    repeat (2) step();
    start = 1'b1; base_addr = AW'(0); burst_len = (AW + 1)'(3);
    step();
    start = 1'b0;
    repeat (17) step();
    for (int g = 0; g < 2; g++) begin
      chk("stall_addr", 32'(rdaddr[g]), 32'd8);
      chk("stall_valid", 32'(out_valid[g]), 32'd1);
      chk("stall_delivered", idx[g], 32'd0);
    end
    out_ready = 1'b1;
    wait_idle("stall", 80);
    for (int g = 0; g < 2; g++) chk("stall_last_word", last_word[g], 32'd20);

    // Pseudo-random ready with enable toggling.
    launch(30, 20);
    lfsr = 16'hACE1;
    c = 0;
    while ((active[0] || active[1]) && c < 1500) begin
      lfsr      = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      enable    = lfsr[0];
      out_ready = lfsr[5];
      step();
      c++;
    end
    enable    = 1'b1;
    out_ready = 1'b1;
    wait_idle("random", 40);
    for (int g = 0; g < 2; g++) chk("random_last_word", last_word[g], 32'd9);

    // Asynchronous reset mid-burst after three words.
    launch(0, 10);
    c = 0;
    while (idx[0] < 3 && c < 50) begin
      @(negedge clk_drv);
      c++;
    end
    chk("reset_wait_words", 32'(idx[0] >= 3), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      active[g] = 1'b0; idx[g] = 0; zero_pend[g] = 1'b0;
      chk("abort_busy", 32'(busy[g]), 32'd0);
      chk("abort_done", 32'(done[g]), 32'd0);
      chk("abort_valid", 32'(out_valid[g]), 32'd0);
      chk("abort_last", 32'(out_last[g]), 32'd0);
      chk("abort_data", out_data[g], 32'd0);
      chk("abort_addr", 32'(rdaddr[g]), 32'd0);
    end
    repeat (2) step();
    reset_n = 1'b1;
    step();
    launch(20, 6);
    check_addrs("addr_after_reset", 20, 6);
    wait_idle("after_reset", 40);
    for (int g = 0; g < 2; g++) chk("after_reset_last_word", last_word[g], 32'd25);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
